// File: rtl/led_anim_seq.sv
// Frame sequencer for the LED pattern decoder: prescaled step counter with play/pause/stop, looping
// and completion pulse. Define LED_ANIM_REVERSE_EN to honour dir (reverse playback); otherwise forward only.
`timescale 1ns/1ps

module led_anim_seq #(
    parameter int TICK_DIV  = 12500000,
    parameter int CNT_W     = 24,
    parameter int LAST_STEP = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop_en,
    input  logic       dir,
    output logic [6:0] step,
    input  logic [6:0] pat_in,
    output logic [6:0] led,
    output logic       busy,
    output logic       frame_tick,
    output logic       done
);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]       STEP_LAST = 7'(LAST_STEP);
    localparam logic [6:0]       LED_OFF   = 7'h7F;

    generate
        if (TICK_DIV < 1 || LAST_STEP < 0 || LAST_STEP > 127 ||
            (TICK_DIV - 1) >= (64'd1 << CNT_W)) begin : g_bad_params
            $error("led_anim_seq: illegal TICK_DIV/CNT_W/LAST_STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_step;
    logic [6:0]       r_led;
    logic             r_busy;
    logic             r_tick;
    logic             r_done;

    logic             w_rev;
    logic             w_at_end;
    logic [6:0]       w_adv_step;
    logic [6:0]       w_start_step;
    logic             w_cnt_wrap;

`ifdef LED_ANIM_REVERSE_EN
    assign w_rev = dir;
`else
    logic w_unused_dir;
    assign w_unused_dir = dir;
    assign w_rev        = 1'b0;
`endif

    assign w_cnt_wrap   = (r_cnt == CNT_MAX);
    assign w_start_step = w_rev ? STEP_LAST : 7'd0;

    // Next step on a frame advance; end-of-sequence wraps are explicit, never 7-bit overflow.
    always_comb begin
        w_at_end   = 1'b0;
        w_adv_step = 7'd0;
`ifdef LED_ANIM_REVERSE_EN
        if (w_rev) begin
            w_at_end   = (r_step == 7'd0);
            w_adv_step = w_at_end ? STEP_LAST : (r_step - 7'd1);
        end else begin
            w_at_end   = (r_step == STEP_LAST);
            w_adv_step = w_at_end ? 7'd0 : (r_step + 7'd1);
        end
`else
        w_at_end   = (r_step == STEP_LAST);
        w_adv_step = w_at_end ? 7'd0 : (r_step + 7'd1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_step  <= 7'd0;
            r_led   <= LED_OFF;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            r_led  <= (r_state == S_IDLE) ? LED_OFF : pat_in;

            if (stop) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_step  <= 7'd0;
                r_busy  <= 1'b0;
            end else if (start) begin
                r_state <= S_RUN;
                r_cnt   <= '0;
                r_step  <= w_start_step;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_RUN, S_HOLD: begin
                        if (pause) begin
                            r_state <= S_HOLD;
                        end else begin
                            // Leaving HOLD counts in the same cycle, so a pause adds exactly its length.
                            r_state <= S_RUN;
                            if (w_cnt_wrap) begin
                                r_cnt <= '0;
                                if (w_at_end && !loop_en) begin
                                    r_state <= S_IDLE;
                                    r_step  <= 7'd0;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_step <= w_adv_step;
                                    r_tick <= 1'b1;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step       = r_step;
    assign led        = r_led;
    assign busy       = r_busy;
    assign frame_tick = r_tick;
    assign done       = r_done;

endmodule

// File: doc/led_anim_seq.md
# led_anim_seq

Frame sequencer that drives the 7-bit step index of the combinational LED pattern decoder and registers the returned 7-bit pattern onto the LED pins. It sits between the board-level controls and the pattern decoder. It provides frame timing (prescaler), play, pause and stop control, looping, an optional reverse direction, and completion signalling.

## Interface
Parameters:
- TICK_DIV, default 12500000: clocks per frame (≥1).
- CNT_W, default 24: prescaler width; must hold TICK_DIV-1.
- LAST_STEP, default 127: final step index (≤127).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: system clock.
  - rst_n, in, 1: asynchronous active-low reset.
- Control inputs:
  - start, in, 1: 1-cycle pulse that starts or restarts the sequence.
  - stop, in, 1: abort to IDLE.
  - pause, in, 1: level; freezes the sequence while high.
  - loop_en, in, 1: 1 = wrap at sequence end; 0 = one-shot.
  - dir, in, 1: 0 = forward, 1 = reverse (see Configuration).
- Decoder interface:
  - step, out, 7: index to the decoder input.
  - pat_in, in, 7: decoder output pattern (combinational from step).
- Status and LED outputs:
  - led, out, 7: registered LED pattern; 1 = LED dark.
  - busy, out, 1: high in RUN and HOLD.
  - frame_tick, out, 1: 1-cycle pulse coincident with each new step value.
  - done, out, 1: 1-cycle pulse on one-shot completion.

## Operation
- States:
  - IDLE: stopped.
  - RUN: prescaler counting.
  - HOLD: paused; prescaler and step frozen.
- Reset (async, immediate) values:
  - State IDLE, prescaler 0.
  - step 0, led 7'h7F.
  - busy 0, frame_tick 0, done 0.
- Input priority within one cycle: stop > start > pause > prescaler tick.
- stop in any state:
  - Go to IDLE; step 0, prescaler 0.
  - No done pulse.
- start in any state, when stop is low:
  - step ← LAST_STEP if reverse is active, else 0.
  - Prescaler ← 0; go to RUN.
  - pause is ignored in the start cycle.
- RUN with pause=1: go to HOLD; the prescaler is not incremented and no tick occurs in that cycle.
- HOLD with pause=0: go to RUN; counting resumes from the frozen prescaler value.
- Prescaler in RUN:
  - Counts 0..TICK_DIV-1.
  - In the cycle where it equals TICK_DIV-1: wrap to 0 and advance step.
- Forward advance:
  - step < LAST_STEP: step+1.
  - step = LAST_STEP with loop_en=1: step ← 0.
  - step = LAST_STEP with loop_en=0: go to IDLE, step ← 0, done pulse.
- Reverse advance:
  - step > 0: step-1.
  - step = 0 with loop_en=1: step ← LAST_STEP.
  - step = 0 with loop_en=0: go to IDLE, step ← 0, done pulse.
- dir and loop_en are sampled at each advance; live changes are allowed.
- led register:
  - RUN/HOLD: led ← pat_in every cycle.
  - IDLE: led ← 7'h7F.
- frame_tick is registered: asserted for the one cycle in which step holds its newly advanced value. It is not asserted on start or on wrap to IDLE.
- done is registered: high for the one cycle in which busy first reads 0 after completion.
- Width rules: step arithmetic is 7-bit. LAST_STEP=127 forward wrap is explicit, never implicit overflow behaviour.

## Timing
- start sampled at edge E0:
  - After E0: step = start value, busy = 1.
  - After E0+1: led = pattern(start value).
- Each frame lasts exactly TICK_DIV cycles in RUN. The first advance occurs at edge E0+TICK_DIV.
- step → led latency: 1 cycle.
- One-shot full sequence: done and busy=0 after edge E0+(LAST_STEP+1)·TICK_DIV. led = 7'h7F one cycle later.
- TICK_DIV=1: step advances on every RUN cycle; frame_tick stays high continuously.
- HOLD adds exactly the paused cycle count to the current frame.

## Configuration
- LED_ANIM_REVERSE_EN defined:
  - dir is honoured as above.
- LED_ANIM_REVERSE_EN undefined:
  - dir is ignored and direction is always forward.
  - start always loads step 0.
  - No decrement logic is synthesized.

## Test plan
- Reset: assert rst_n low mid-RUN at step 9 → step 0, led 7'h7F, busy 0 immediately, with no clock needed.
- One-shot forward (TICK_DIV=4, loop_en=0): start → step increments every 4 cycles. At step 3, led reads 7'b0110111 one cycle later. The done pulse and busy=0 occur 512 cycles after start.
- Loop (TICK_DIV=4, loop_en=1):
  - step 127 → 0 after 4 cycles.
  - frame_tick is asserted on the step-0 cycle.
  - No done pulse; busy stays 1.
- Pause with prescaler at 2 (TICK_DIV=4):
  - Hold for 10 cycles → step and led unchanged, no frame_tick.
  - After release, step advances 2 cycles later.
- Reverse (macro defined, dir=1): start → step 127, led 7'b1001111, then 126 after TICK_DIV. With the macro undefined, the same stimulus gives step 0.
- Simultaneous stop+start at step 50 → IDLE, step 0, led 7'h7F next cycle, done stays 0.
